// File: rtl/s2_t21_if.sv
// Vital-signs bus for s2_t21: sensor readings, static thresholds, the
// worn qualifier and the two registered results.
// All 8-bit fields are declared [0:7] so that bit [0] is the MSB.
// There is no valid/ready handshake on this bus. X is a level qualifier
// sampled every clock together with the readings, and D/E are
// unconditionally valid one clock after the edge that sampled them.
interface s2_t21_if;
   logic [0:7] A;   // SpO2 reading
   logic [0:7] B;   // heart-rate reading
   logic [0:7] C;   // temperature excess code
   logic [0:7] F1;  // heart-rate low limit
   logic [0:7] F2;  // SpO2 target
   logic [0:7] F3;  // heart-rate high limit
   logic [0:7] F4;  // temperature-excess limit
   logic       X;   // ring worn / readings valid
   logic [0:7] D;   // oxygen delivery amount
   logic       E;   // emergency flag

   modport master (output A, B, C, F1, F2, F3, F4, X, input D, E);
   modport slave  (input A, B, C, F1, F2, F3, F4, X, output D, E);
endinterface

// File: rtl/s2_t21.sv
// s2_t21: vital-signs monitor. Compares SpO2, heart rate and temperature
// excess against static thresholds and registers an oxygen delivery amount
// (D) and an emergency flag (E) one clock after sampling.
// Optional feature macro: S2_T21_PERSIST_EN -- E only asserts once the
// abnormal condition has been seen on 4 consecutive samples.
module s2_t21 (
   input  logic     clk,
   input  logic     rst_n,
   s2_t21_if.slave  bus
);

   logic       sa;     // SpO2 below target
   logic       ha;     // heart rate outside [F1, F3]
   logic       ta;     // temperature excess above limit
   logic       ab;     // qualified abnormal condition
   logic [0:7] d_nxt;
   logic       e_nxt;

`ifdef S2_T21_PERSIST_EN
   logic [1:0] cnt;     // consecutive abnormal samples, saturating at 3
   logic [1:0] cnt_nxt;
`endif

   // Threshold comparisons and next-output computation; all unsigned 8-bit.
   always_comb begin
      sa    = bus.A < bus.F2;
      ha    = (bus.B < bus.F1) || (bus.B > bus.F3);
      ta    = bus.C > bus.F4;
      ab    = bus.X && (sa || ha || ta);
      d_nxt = 8'h00;
      if (bus.X && sa) begin
         // A < F2 here, so the difference cannot wrap.
         d_nxt = bus.F2 - bus.A;
      end
`ifdef S2_T21_PERSIST_EN
      // Count runs of ab; any clear sample (including X=0) restarts the run.
      cnt_nxt = 2'd0;
      if (ab) begin
         cnt_nxt = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
      end
      // Fourth consecutive abnormal sample is the one seen with cnt at 3.
      e_nxt = ab && (cnt == 2'd3);
`else
      e_nxt = ab;
`endif
   end

   // Output registers; reset clears outputs immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.D <= 8'h00;
         bus.E <= 1'b0;
      end else begin
         bus.D <= d_nxt;
         bus.E <= e_nxt;
      end
   end

`ifdef S2_T21_PERSIST_EN
   // Persistence counter; reset discards any partial run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 2'd0;
      end else begin
         cnt <= cnt_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_s2_t21.sv
// Directed testbench for s2_t21. Expected values are hand-computed from the
// nominal thresholds F1=0x37, F2=0x72, F3=0x95, F4=0x18. Works in both the
// default build and with S2_T21_PERSIST_EN defined.
module tb_s2_t21;

`ifdef S2_T21_PERSIST_EN
   localparam int HOLD = 4;
   localparam logic E_FIRST = 1'b0;  // E after one abnormal edge
`else
   localparam int HOLD = 1;
   localparam logic E_FIRST = 1'b1;
`endif

   // Clock and reset
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   s2_t21_if bus ();

   s2_t21 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      logic [7:0] exp_d;
      logic       exp_e;
   } vec_t;

   vec_t vecs[12];

   // Checker
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   // Drivers
   task automatic drive(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic x);
      bus.A = a;
      bus.B = b;
      bus.C = c;
      bus.X = x;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{8'h72, 8'h95, 8'h10, 8'h00, 1'b0};
      vecs[1]  = '{8'h72, 8'h96, 8'h10, 8'h00, 1'b1};
      vecs[2]  = '{8'h72, 8'h37, 8'h10, 8'h00, 1'b0};
      vecs[3]  = '{8'h72, 8'h36, 8'h10, 8'h00, 1'b1};
      vecs[4]  = '{8'h72, 8'h50, 8'h18, 8'h00, 1'b0};
      vecs[5]  = '{8'h72, 8'h50, 8'h19, 8'h00, 1'b1};
      vecs[6]  = '{8'h00, 8'h50, 8'h10, 8'h72, 1'b1};
      vecs[7]  = '{8'h72, 8'h50, 8'h10, 8'h00, 1'b0};
      vecs[8]  = '{8'h71, 8'h50, 8'h10, 8'h01, 1'b1};
      vecs[9]  = '{8'h73, 8'h50, 8'h10, 8'h00, 1'b0};
      vecs[10] = '{8'h72, 8'hFF, 8'h10, 8'h00, 1'b1};
      vecs[11] = '{8'h72, 8'h00, 8'h00, 8'h00, 1'b1};

      bus.F1 = 8'h37;
      bus.F2 = 8'h72;
      bus.F3 = 8'h95;
      bus.F4 = 8'h18;
      drive(8'h00, 8'h50, 8'h10, 1'b1);

      // Outputs become non-zero on the first edge, then reset mid-cycle.
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_d", {7'd0, 1'b0} | bus.D, 8'h00);
      check("rst_e", {7'd0, bus.E}, 8'h00);
      step();
      check("rst_hold_d", bus.D, 8'h00);
      check("rst_hold_e", {7'd0, bus.E}, 8'h00);

      // Release and check first edge samples normally.
      @(negedge clk);
      rst_n = 1'b1;
      drive(8'h60, 8'h50, 8'h10, 1'b1);
      step();
      check("rel_d", bus.D, 8'h12);
      check("rel_e", {7'd0, bus.E}, {7'd0, E_FIRST});

      // Normal vitals
      drive(8'h72, 8'h50, 8'h10, 1'b1);
      step();
      check("norm_d", bus.D, 8'h00);
      check("norm_e", {7'd0, bus.E}, 8'h00);

      // Low SpO2
      drive(8'h60, 8'h50, 8'h10, 1'b1);
      step();
      check("low_d", bus.D, 8'h12);
      check("low_e1", {7'd0, bus.E}, {7'd0, E_FIRST});
`ifdef S2_T21_PERSIST_EN
      step();
      check("low_e2", {7'd0, bus.E}, 8'h00);
      step();
      check("low_e3", {7'd0, bus.E}, 8'h00);
      step();
      check("low_e4", {7'd0, bus.E}, 8'h01);
      check("low_d4", bus.D, 8'h12);
`endif

      // Boundary table; each vector held long enough for E to settle.
      foreach (vecs[i]) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
         repeat (HOLD) step();
         check($sformatf("bnd%0d_d", i), bus.D, vecs[i].exp_d);
         check($sformatf("bnd%0d_e", i), {7'd0, bus.E}, {7'd0, vecs[i].exp_e});
      end

      // Not worn, then worn again
      drive(8'h00, 8'hFF, 8'hFF, 1'b0);
      step();
      check("nw_d", bus.D, 8'h00);
      check("nw_e", {7'd0, bus.E}, 8'h00);
      drive(8'h00, 8'hFF, 8'hFF, 1'b1);
      step();
      check("worn_d", bus.D, 8'h72);
      check("worn_e", {7'd0, bus.E}, {7'd0, E_FIRST});

`ifdef S2_T21_PERSIST_EN
      // X=0 mid-run clears the count.
      repeat (2) step();
      drive(8'h00, 8'hFF, 8'hFF, 1'b0);
      step();
      drive(8'h00, 8'hFF, 8'hFF, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("xclr_e%0d", k), {7'd0, bus.E}, (k == 4) ? 8'h01 : 8'h00);
      end

      // Three abnormal edges then normal: E never asserts.
      drive(8'h72, 8'h50, 8'h10, 1'b1);
      step();
      drive(8'h72, 8'h50, 8'h19, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("p3_e%0d", k), {7'd0, bus.E}, 8'h00);
      end
      drive(8'h72, 8'h50, 8'h10, 1'b1);
      step();
      check("p3_clr_e", {7'd0, bus.E}, 8'h00);

      // Four abnormal edges: E on the fourth, stays while abnormal.
      drive(8'h72, 8'h50, 8'h19, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         step();
         check($sformatf("p4_e%0d", k), {7'd0, bus.E}, (k >= 4) ? 8'h01 : 8'h00);
      end
      drive(8'h72, 8'h50, 8'h10, 1'b1);
      step();
      check("p4_drop_e", {7'd0, bus.E}, 8'h00);

      // Reset mid-run discards the partial count.
      drive(8'h72, 8'h50, 8'h19, 1'b1);
      repeat (2) step();
      #2;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("prst_e%0d", k), {7'd0, bus.E}, (k == 4) ? 8'h01 : 8'h00);
      end
`endif

      // E clears on the first normal edge.
      drive(8'h72, 8'h50, 8'h10, 1'b1);
      step();
      check("end_d", bus.D, 8'h00);
      check("end_e", {7'd0, bus.E}, 8'h00);

      // Report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/s2_t21.md
S2_T21 -- requirements
Module: s2_t21

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 A  input  8  SpO2 sensor reading, unsigned; bit [0] is the MSB for all 8-bit ports.
REQ-005 B  input  8  heart-rate sensor reading, unsigned.
REQ-006 C  input  8  body-temperature excess code above baseline, unsigned.
REQ-007 F1  input  8  heart-rate low limit, static threshold; nominal value 0x37.
REQ-008 F2  input  8  SpO2 target, static threshold; nominal value 0x72.
REQ-009 F3  input  8  heart-rate high limit, static threshold; nominal value 0x95.
REQ-010 F4  input  8  temperature-excess limit, static threshold; nominal value 0x18.
REQ-011 X  input  1  ring-worn/valid qualifier; 1 means the readings are valid.
REQ-012 D  output  8  oxygen delivery amount, registered.
REQ-013 E  output  1  emergency flag, registered.

Function
REQ-014 The block SHALL sample A, B, C, F1-F4 and X on every rising edge of clk.
REQ-015 All comparisons SHALL be unsigned 8-bit.
REQ-016 SpO2 abnormal (sa) SHALL be A < F2; A == F2 SHALL be normal.
REQ-017 Heart-rate abnormal (ha) SHALL be B < F1 or B > F3; B == F1 and B == F3 SHALL be normal.
REQ-018 Temperature abnormal (ta) SHALL be C > F4; C == F4 SHALL be normal.
REQ-019 Abnormal flag ab SHALL be X & (sa | ha | ta).
REQ-020 With X=1, D SHALL register F2 - A when A < F2, else 0x00; the result cannot underflow or wrap.
REQ-021 With X=0, D SHALL register 0x00.
REQ-022 Latency SHALL be one clock from sampling edge to D/E update.
REQ-023 Without the persistence feature, E SHALL register ab.
REQ-024 E SHALL NOT be sticky; it deasserts on the first edge after ab clears (subject to REQ-029).
REQ-025 X=0 SHALL force D=0, E=0 and clear any persistence count on the same edge.
REQ-026 There SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 On rst_n low, D SHALL be 0x00, E SHALL be 0 and the persistence counter SHALL be 0, immediately and regardless of clk.
REQ-028 After rst_n deasserts, the first rising edge of clk SHALL perform normal sampling; a reset mid-sequence SHALL discard any partial persistence count.

Configuration
REQ-029 With S2_T21_PERSIST_EN defined:
- a 2-bit saturating counter SHALL increment on each edge where ab=1 and clear on any edge where ab=0;
- E SHALL assert on the edge where ab has been 1 for 4 consecutive samples, i.e. it samples ab=1 with the counter at 3;
- E SHALL remain asserted while ab stays 1, and deassert on the first edge where ab=0.
REQ-030 Without S2_T21_PERSIST_EN, the counter SHALL be absent and REQ-023 SHALL apply.
REQ-031 D SHALL be independent of the macro.

Verification
Scenarios use F1=0x37, F2=0x72, F3=0x95, F4=0x18 and X=1 unless stated.
REQ-032 Reset: drive rst_n=0 with A=0x00 -> D=0x00, E=0 asynchronously; release rst_n -> correct outputs after the next edge.
REQ-033 Normal vitals: A=0x72, B=0x50, C=0x10 -> D=0x00, E=0 one cycle later.
REQ-034 Low SpO2: A=0x60, B=0x50, C=0x10 -> D=0x12. E=1 after 1 cycle without the macro, after the 4th edge with it.
REQ-035 Boundaries:
- B=0x95 -> E=0; B=0x96 -> E=1.
- B=0x37 -> E=0; B=0x36 -> E=1.
- C=0x18 -> E=0; C=0x19 -> E=1.
- A=0x00 -> D=0x72.
REQ-036 Not worn: X=0 with A=0x00, B=0xFF, C=0xFF -> D=0x00, E=0; then X=1 -> D=0x72, E per the macro setting.
REQ-037 Persistence (macro on): ab=1 for 3 edges then ab=0 -> E stays 0; ab=1 for 4 edges -> E=1 on the 4th edge.
